// File: rtl/filterbank_pkg.sv
// Shared constants and types for the serial 16-band filterbank.
package filterbank_pkg;

    localparam int NUM_TAPS  = 119;
    localparam int NUM_BANDS = 16;
    localparam int SAMPLE_W  = 10;
    localparam int OUT_W     = 27;

    // Sequencer states. DRAIN is only visited when the MAC pipeline has latency.
    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        RUN,
        DRAIN,
        DONE
    } seq_state_t;

endpackage

// File: rtl/filterbank_sequencer.sv
// Per-sample sequencer for the serial filterbank: loads one sample into the
// shared delay line, steps the MAC phase through every tap pair, waits out the
// MAC pipeline and then flags the band outputs as final.
module filterbank_sequencer
    import filterbank_pkg::*;
#(
    parameter int CYCLES_PER_SAMPLE = 60,
    parameter int MAC_LAT           = 2,
    parameter int PHASE_W           = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clk_enable,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               ovr_clr,
    output logic               shift_en,
    output logic [PHASE_W-1:0] phase,
    output logic               acc_clear,
    output logic               acc_en,
    output logic               out_valid,
    output logic               busy,
    output logic               overrun
);

    // The same counter walks the RUN phases and then the DRAIN cycles, so it
    // must be wide enough for both.
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(CYCLES_PER_SAMPLE - 1);
    localparam logic [PHASE_W-1:0] LAST_DRAIN = PHASE_W'((MAC_LAT > 0) ? (MAC_LAT - 1) : 0);

    seq_state_t         state_q;
    logic [PHASE_W-1:0] cnt_q;
    logic [PHASE_W-1:0] phase_q;
    logic               in_ready_q;
    logic               shift_en_q;
    logic               acc_clear_q;
    logic               acc_en_q;
    logic               out_valid_q;
    logic               busy_q;
    logic               overrun_q;
    logic               in_valid_q;

    // A held in_valid is a source waiting for in_ready; only a newly asserted
    // in_valid while busy represents a sample that is lost.
    logic new_sample;
    assign new_sample = in_valid && !in_valid_q;

    // Sequencer FSM with all outputs registered; clk_enable=0 freezes state
    // and silences every pulse output, reset overrides the freeze.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            phase_q     <= '0;
            in_ready_q  <= 1'b1;
            shift_en_q  <= 1'b0;
            acc_clear_q <= 1'b0;
            acc_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            in_valid_q  <= 1'b0;
        end else if (!clk_enable) begin
            shift_en_q  <= 1'b0;
            acc_clear_q <= 1'b0;
            acc_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            shift_en_q  <= 1'b0;
            acc_clear_q <= 1'b0;
            acc_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
            in_valid_q  <= in_valid;

            // A fresh overrun event wins over a simultaneous clear.
            if (new_sample && !in_ready_q) begin
                overrun_q <= 1'b1;
            end else if (ovr_clr) begin
                overrun_q <= 1'b0;
            end

            case (state_q)
                IDLE, DONE: begin
                    if (in_valid) begin
                        state_q    <= SHIFT;
                        shift_en_q <= 1'b1;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end else begin
                        state_q    <= IDLE;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                SHIFT: begin
                    state_q     <= RUN;
                    cnt_q       <= '0;
                    phase_q     <= '0;
                    acc_en_q    <= 1'b1;
                    acc_clear_q <= 1'b1;
                end
                RUN: begin
                    if (cnt_q == LAST_PHASE) begin
                        cnt_q <= '0;
                        if (MAC_LAT == 0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b1;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end else begin
                        cnt_q    <= cnt_q + 1'b1;
                        phase_q  <= cnt_q + 1'b1;
                        acc_en_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    // phase_q holds the last tap pair while the MAC pipeline empties.
                    if (cnt_q == LAST_DRAIN) begin
                        cnt_q       <= '0;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign shift_en  = shift_en_q;
    assign phase     = phase_q;
    assign acc_clear = acc_clear_q;
    assign acc_en    = acc_en_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_filterbank_sequencer.sv
// Directed bench for filterbank_sequencer: default build (MAC_LAT=2) and a
// MAC_LAT=0 build side by side.
module tb_filterbank_sequencer;

    logic       clock;
    logic       reset;
    logic       clk_enable;
    logic       in_valid;
    logic       ovr_clr;
    logic       in_ready, shift_en, acc_clear, acc_en, out_valid, busy, overrun;
    logic [5:0] phase;

    logic       in_valid0;
    logic       in_ready0, shift_en0, acc_clear0, acc_en0, out_valid0, busy0, overrun0;
    logic [5:0] phase0;

    int compared   = 0;
    int mismatched = 0;

    filterbank_sequencer #(.CYCLES_PER_SAMPLE(60), .MAC_LAT(2), .PHASE_W(6)) dut (
        .clock(clock), .reset(reset), .clk_enable(clk_enable), .in_valid(in_valid),
        .in_ready(in_ready), .ovr_clr(ovr_clr), .shift_en(shift_en), .phase(phase),
        .acc_clear(acc_clear), .acc_en(acc_en), .out_valid(out_valid), .busy(busy),
        .overrun(overrun)
    );

    filterbank_sequencer #(.CYCLES_PER_SAMPLE(60), .MAC_LAT(0), .PHASE_W(6)) dut0 (
        .clock(clock), .reset(reset), .clk_enable(1'b1), .in_valid(in_valid0),
        .in_ready(in_ready0), .ovr_clr(1'b0), .shift_en(shift_en0), .phase(phase0),
        .acc_clear(acc_clear0), .acc_en(acc_en0), .out_valid(out_valid0), .busy(busy0),
        .overrun(overrun0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    // Called in cycle 1 (just after the accepting edge E0). Checks one full
    // sample at MAC_LAT=2. ovr_at: cycle in which a stray in_valid pulse is
    // driven (0 = none). fs/flen: clk_enable held low for edges fs..fs+flen-1.
    task automatic check_seq(input string tag, input int ovr_at, input int fs, input int flen);
        int e;
        bit frz;
        in_valid = 1'b0;
        for (int c = 1; c <= 65 + flen; c++) begin
            frz = (flen > 0) && (c > fs) && (c <= fs + flen);
            if (frz)                            e = fs;
            else if ((flen > 0) && (c > fs))    e = c - flen;
            else                                e = c;
            chk({tag, "_shift_en"},  c, shift_en,  !frz && (e == 1));
            chk({tag, "_acc_clear"}, c, acc_clear, !frz && (e == 2));
            chk({tag, "_acc_en"},    c, acc_en,    !frz && (e >= 2) && (e <= 61));
            chk({tag, "_out_valid"}, c, out_valid, !frz && (e == 64));
            chk({tag, "_in_ready"},  c, in_ready,  e >= 64);
            chk({tag, "_busy"},      c, busy,      e <= 64);
            chk({tag, "_overrun"},   c, overrun,   (ovr_at > 0) && (c > ovr_at));
            if ((e >= 2) && (e <= 63))
                chk({tag, "_phase"}, c, phase, (e <= 61) ? (e - 2) : 59);
            in_valid   = (c == ovr_at);
            clk_enable = !((flen > 0) && (c >= fs) && (c < fs + flen));
            step();
        end
        in_valid   = 1'b0;
        clk_enable = 1'b1;
    endtask

    initial begin
        int n_ov;
        int n_sh;
        reset      = 1'b1;
        clk_enable = 1'b1;
        in_valid   = 1'b0;
        in_valid0  = 1'b0;
        ovr_clr    = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_in_ready",  0, in_ready,  1);
        chk("rst_shift_en",  0, shift_en,  0);
        chk("rst_phase",     0, phase,     0);
        chk("rst_acc_en",    0, acc_en,    0);
        chk("rst_acc_clear", 0, acc_clear, 0);
        chk("rst_out_valid", 0, out_valid, 0);
        chk("rst_busy",      0, busy,      0);
        chk("rst_overrun",   0, overrun,   0);
        reset = 1'b0;
        step();

        // 1. single sample
        in_valid = 1'b1;
        step();
        check_seq("t1", 0, 0, 0);

        // 2. in_valid held for three back-to-back samples
        in_valid = 1'b1;
        step();
        for (int c = 1; c <= 193; c++) begin
            chk("t2_shift_en",  c, shift_en,  (c == 1) || (c == 65) || (c == 129));
            chk("t2_acc_clear", c, acc_clear, (c % 64) == 2);
            chk("t2_out_valid", c, out_valid, (c % 64) == 0);
            chk("t2_overrun",   c, overrun,   0);
            if (c == 192) in_valid = 1'b0;
            step();
        end

        // 3. stray sample at phase 10 -> overrun, sequence unaffected
        in_valid = 1'b1;
        step();
        check_seq("t3", 12, 0, 0);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("t3_ovr_clr", 0, overrun, 0);
        // overrun event and clear in the same cycle: overrun wins
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        in_valid = 1'b1;
        ovr_clr  = 1'b1;
        step();
        in_valid = 1'b0;
        ovr_clr  = 1'b0;
        chk("t3_clr_vs_set", 6, overrun, 1);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("t3_clr_again", 7, overrun, 0);
        repeat (60) step();
        chk("t3_idle", 67, busy, 0);

        // 4. freeze for 5 cycles at phase 30
        in_valid = 1'b1;
        step();
        check_seq("t4", 0, 32, 5);

        // 5. reset at phase 20 (while frozen: reset must still act)
        in_valid = 1'b1;
        step();
        for (int c = 1; c <= 21; c++) begin
            in_valid = (c == 15);
            step();
        end
        in_valid = 1'b0;
        chk("t5_phase_before", 22, phase,   20);
        chk("t5_ovr_before",   22, overrun, 1);
        reset      = 1'b1;
        clk_enable = 1'b0;
        step();
        reset      = 1'b0;
        clk_enable = 1'b1;
        chk("t5_in_ready", 23, in_ready, 1);
        chk("t5_busy",     23, busy,     0);
        chk("t5_phase",    23, phase,    0);
        chk("t5_overrun",  23, overrun,  0);
        chk("t5_acc_en",   23, acc_en,   0);
        n_ov = 0;
        n_sh = 0;
        for (int c = 0; c < 70; c++) begin
            if (out_valid === 1'b1) n_ov++;
            if (shift_en === 1'b1)  n_sh++;
            step();
        end
        chk("t5_no_out_valid", 0, n_ov, 0);
        chk("t5_no_shift_en",  0, n_sh, 0);
        in_valid = 1'b1;
        step();
        check_seq("t5b", 0, 0, 0);

        // 6. MAC_LAT=0 build
        in_valid0 = 1'b1;
        step();
        in_valid0 = 1'b0;
        for (int c = 1; c <= 63; c++) begin
            chk("t6_shift_en",  c, shift_en0,  c == 1);
            chk("t6_acc_en",    c, acc_en0,    (c >= 2) && (c <= 61));
            chk("t6_out_valid", c, out_valid0, c == 62);
            chk("t6_in_ready",  c, in_ready0,  c >= 62);
            chk("t6_busy",      c, busy0,      c <= 62);
            if ((c >= 2) && (c <= 62))
                chk("t6_phase", c, phase0, (c <= 61) ? (c - 2) : 59);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
